// File: rtl/ws2812_chain_tx_if.sv
// ws2812_chain_tx_if: handshake, frame-RAM and LED pin signals of ws2812_chain_tx.
// The brightness signal exists only when BRIGHTNESS_SCALE_EN is defined.
interface ws2812_chain_tx_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              continuous;
  logic              busy;
  logic              frame_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              led_dout;
`ifdef BRIGHTNESS_SCALE_EN
  logic [7:0]        brightness;

  modport master (
    output start, continuous, mem_data, brightness,
    input  busy, frame_done, mem_addr, led_dout
  );

  modport slave (
    input  start, continuous, mem_data, brightness,
    output busy, frame_done, mem_addr, led_dout
  );
`else
  modport master (
    output start, continuous, mem_data,
    input  busy, frame_done, mem_addr, led_dout
  );

  modport slave (
    input  start, continuous, mem_data,
    output busy, frame_done, mem_addr, led_dout
  );
`endif
endinterface

// File: rtl/ws2812_chain_tx.sv
// ws2812_chain_tx: streams a byte frame from synchronous-read RAM to a
// WS2812-class LED chain (MSB first, pulse-width coded bits, then a latch gap).
// The next byte is prefetched during the current byte so bit periods stay gapless.
// Optional: define BRIGHTNESS_SCALE_EN to scale every byte by a per-frame
// brightness value, latched at PRIME.
//
// state | meaning
// IDLE  | waiting for start, pin low, mem_addr at 0
// PRIME | byte 0 is on mem_data; load it and point mem_addr at byte 1
// HIGH  | high part of the current bit symbol
// LOW   | low part of the current bit symbol; the next byte sits on mem_data
// GAP   | end-of-frame latch gap, pin low
module ws2812_chain_tx #(
  parameter int NUM_LEDS      = 35,
  parameter int BYTES_PER_LED = 3,
  parameter int ADDR_W        = 8,
  parameter int T0H           = 20,
  parameter int T0L           = 42,
  parameter int T1H           = 40,
  parameter int T1L           = 22,
  parameter int TRESET        = 3000,
  parameter int CNT_W         = 16
) (
  input logic              clk,
  input logic              rst,
  ws2812_chain_tx_if.slave bus
);
  localparam int NBYTES = NUM_LEDS * BYTES_PER_LED;
  localparam logic [ADDR_W:0]   LAST_BYTE  = (ADDR_W+1)'(NBYTES - 1);
  localparam logic [ADDR_W:0]   NBYTES_W   = (ADDR_W+1)'(NBYTES);
  localparam logic [ADDR_W-1:0] ADDR_FIRST = (NBYTES > 1) ? ADDR_W'(1) : '0;
  localparam logic [CNT_W-1:0]  C_T0H      = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0]  C_T0L      = CNT_W'(T0L - 1);
  localparam logic [CNT_W-1:0]  C_T1H      = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0]  C_T1L      = CNT_W'(T1L - 1);
  localparam logic [CNT_W-1:0]  C_TRESET   = CNT_W'(TRESET - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_HIGH, S_LOW, S_GAP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        shift;
  logic [7:0]        byte_in;
  logic [2:0]        bit_idx;
  logic [ADDR_W-1:0] byte_idx;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W:0]   addr_plus2;
  logic              tc, last_bit, last_byte;
  logic              led_d, busy_d, gap_end_d;
  logic              led_q, busy_q, gap_end_q, done_q;

  function automatic logic [CNT_W-1:0] high_len(input logic b);
    return b ? C_T1H : C_T0H;
  endfunction

  function automatic logic [CNT_W-1:0] low_len(input logic b);
    return b ? C_T1L : C_T0L;
  endfunction

  assign tc         = (cnt == '0);
  assign last_bit   = (bit_idx == 3'd0);
  assign last_byte  = ({1'b0, byte_idx} == LAST_BYTE);
  assign addr_plus2 = {1'b0, byte_idx} + (ADDR_W+1)'(2);

`ifdef BRIGHTNESS_SCALE_EN
  logic [7:0]  bright_q;
  logic [7:0]  bright_sel;
  logic [16:0] product;

  // Byte 0 is loaded in the same cycle brightness is latched, so use the live value there.
  assign bright_sel = (state == S_PRIME) ? bus.brightness : bright_q;
  assign product    = 17'(bus.mem_data) * 17'({1'b0, bright_sel} + 9'd1);
  assign byte_in    = 8'(product >> 8);

  // Hold the frame's brightness from PRIME onwards.
  always_ff @(posedge clk) begin
    if (rst)                   bright_q <= '0;
    else if (state == S_PRIME) bright_q <= bus.brightness;
  end
`else
  assign byte_in = bus.mem_data;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_PRIME;
      S_PRIME: state_nxt = S_HIGH;
      S_HIGH:  if (tc) state_nxt = S_LOW;
      S_LOW:   if (tc) state_nxt = (last_bit && last_byte) ? S_GAP : S_HIGH;
      S_GAP:   if (tc) state_nxt = bus.continuous ? S_PRIME : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode; registered below so every pin is a flop output.
  always_comb begin
    led_d     = (state == S_HIGH);
    busy_d    = (state != S_IDLE);
    gap_end_d = (state == S_GAP) && tc;
  end

  // Output registers. led_dout lags state by one cycle, so frame_done takes a
  // second stage to land exactly where the gap ends on the pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      gap_end_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      led_q     <= led_d;
      busy_q    <= busy_d;
      gap_end_q <= gap_end_d;
      done_q    <= gap_end_q;
    end
  end

  // Symbol timer, shifter and byte prefetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      shift      <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      mem_addr_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt        <= '0;
          mem_addr_q <= '0;
        end
        S_PRIME: begin
          shift      <= byte_in;
          mem_addr_q <= ADDR_FIRST;
          bit_idx    <= 3'd7;
          byte_idx   <= '0;
          cnt        <= high_len(byte_in[7]);
        end
        S_HIGH: begin
          if (tc) cnt <= low_len(shift[7]);
          else    cnt <= cnt - CNT_W'(1);
        end
        S_LOW: begin
          if (!tc) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!last_bit) begin
            shift   <= {shift[6:0], 1'b0};
            bit_idx <= bit_idx - 3'd1;
            cnt     <= high_len(shift[6]);
          end else if (!last_byte) begin
            shift      <= byte_in;
            byte_idx   <= byte_idx + ADDR_W'(1);
            mem_addr_q <= (addr_plus2 < NBYTES_W) ? addr_plus2[ADDR_W-1:0] : '0;
            bit_idx    <= 3'd7;
            cnt        <= high_len(byte_in[7]);
          end else begin
            mem_addr_q <= '0;
            cnt        <= C_TRESET;
          end
        end
        S_GAP: begin
          if (tc) cnt <= '0;
          else    cnt <= cnt - CNT_W'(1);
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign bus.led_dout   = led_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.mem_addr   = mem_addr_q;
endmodule

// File: tb/tb_ws2812_chain_tx.sv
// tb_ws2812_chain_tx: scoreboard bench for ws2812_chain_tx. Expected bits are
// queued when a frame is started and popped as the pin monitor decodes symbols.
module tb_ws2812_chain_tx;
  localparam int NUM_LEDS = 2;
  localparam int BPL      = 3;
  localparam int ADDR_W   = 8;
  localparam int T0H      = 2;
  localparam int T0L      = 4;
  localparam int T1H      = 4;
  localparam int T1L      = 2;
  localparam int TRESET   = 10;
  localparam int CNT_W    = 16;
  localparam int NBYTES   = NUM_LEDS * BPL;
  localparam int NBITS    = NBYTES * 8;
  localparam int FRAME    = NBITS * 6 + TRESET;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ws2812_chain_tx_if #(.ADDR_W(ADDR_W)) bus ();

  ws2812_chain_tx #(
    .NUM_LEDS(NUM_LEDS), .BYTES_PER_LED(BPL), .ADDR_W(ADDR_W),
    .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L), .TRESET(TRESET), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0] ram [256];
  always @(posedge clk) bus.mem_data <= ram[bus.mem_addr];

  int total = 0;
  int bad   = 0;
  bit exp_q[$];
  int addr_log[$];
  int bits_seen = 0;
  int done_seen = 0;

  function automatic logic [7:0] scale(input logic [7:0] v);
`ifdef BRIGHTNESS_SCALE_EN
    int p;
    p = int'(v) * (int'(bus.brightness) + 1);
    return 8'(p >> 8);
`else
    return v;
`endif
  endfunction

  function automatic void push_frame();
    for (int i = 0; i < NBYTES; i++) begin
      logic [7:0] b;
      b = scale(ram[i]);
      for (int j = 7; j >= 0; j--) exp_q.push_back(b[j]);
    end
  endfunction

  // Pin monitor: decode high/low widths, pop the scoreboard, check gap length at frame_done.
  logic prev_led = 1'b0, have_bit = 1'b0, last_b = 1'b0, chk_gap = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  int hi_cnt = 0, lo_cnt = 0, fbits = 0;
  always @(negedge clk) begin : mon
    bit e;
    if (bus.mem_addr !== prev_addr) addr_log.push_back(int'(bus.mem_addr));
    prev_addr = bus.mem_addr;
    if (rst) begin
      prev_led = 0; have_bit = 0; chk_gap = 0; hi_cnt = 0; lo_cnt = 0; fbits = 0;
    end else begin
      if (bus.led_dout === 1'b1) begin
        if (!prev_led) begin
          if (have_bit) begin
            total++;
            if (lo_cnt != (last_b ? T1L : T0L)) begin
              bad++;
              $display("FAIL low_width bit=%0d got=%0d want=%0d", bits_seen, lo_cnt, last_b ? T1L : T0L);
            end
          end
          have_bit = 0;
          hi_cnt = 0;
        end
        hi_cnt++;
      end else begin
        if (prev_led) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            e = (hi_cnt == T1H);
            $display("FAIL unexpected_bit high=%0d want=no_bit", hi_cnt);
          end else begin
            e = exp_q.pop_front();
            if (hi_cnt != (e ? T1H : T0H)) begin
              bad++;
              $display("FAIL high_width bit=%0d got=%0d want=%0d", bits_seen, hi_cnt, e ? T1H : T0H);
            end
          end
          last_b = e;
          bits_seen++;
          fbits++;
          lo_cnt = 0;
          if (fbits == NBITS) begin
            fbits = 0; have_bit = 0; chk_gap = 1;
          end else begin
            have_bit = 1;
          end
        end
        lo_cnt++;
      end
      if (bus.frame_done === 1'b1) begin
        done_seen++;
        total++;
        if (!chk_gap || lo_cnt != (last_b ? T1L : T0L) + TRESET + 1) begin
          bad++;
          $display("FAIL gap_len frame_end=%0d got=%0d want=%0d", chk_gap, lo_cnt, (last_b ? T1L : T0L) + TRESET + 1);
        end
        chk_gap = 0;
      end
      prev_led = bus.led_dout;
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.led_dout !== 1'b0)   begin bad++; $display("FAIL rst_led got=%b want=0", bus.led_dout); end
    total++; if (bus.busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", bus.frame_done); end
    total++; if (bus.mem_addr !== '0)     begin bad++; $display("FAIL rst_addr got=%0d want=0", bus.mem_addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One full frame: latency, frame_done timing, busy, prefetch address sequence.
  task automatic run_frame(input string tag, input bit hold);
    int k, d, n0, d0, busy_low;
    push_frame();
    n0 = bits_seen; d0 = done_seen; busy_low = 0;
    addr_log.delete();
    bus.start = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!hold) bus.start = 1'b0;
      if (k == 1) begin
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s busy_early got=%b want=0", tag, bus.busy); end
      end
      if (k == 2) begin
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s busy_rise got=%b want=1", tag, bus.busy); end
      end
    end while (bus.led_dout !== 1'b1 && k < 10);
    total++; if (k != 3) begin bad++; $display("FAIL %s latency got=%0d want=3", tag, k); end
    d = 0;
    while (bus.frame_done !== 1'b1 && d < 1000) begin
      @(negedge clk);
      d++;
      if (hold && d == FRAME - 8) bus.start = 1'b0;
      if (bus.frame_done !== 1'b1 && bus.busy !== 1'b1) busy_low++;
    end
    bus.start = 1'b0;
    total++; if (d != FRAME) begin bad++; $display("FAIL %s done_time got=%0d want=%0d", tag, d, FRAME); end
    total++; if (busy_low != 0) begin bad++; $display("FAIL %s busy_hold low_cycles=%0d want=0", tag, busy_low); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s busy_fall got=%b want=0", tag, bus.busy); end
    repeat (hold ? 350 : 20) @(negedge clk);
    total++;
    if (addr_log.size() != NBYTES) begin
      bad++; $display("FAIL %s addr_seq got=%p want=1..%0d,0", tag, addr_log, NBYTES - 1);
    end else begin
      for (int i = 0; i < NBYTES; i++)
        if (addr_log[i] != ((i + 1) % NBYTES)) begin
          bad++; $display("FAIL %s addr_seq idx=%0d got=%0d want=%0d", tag, i, addr_log[i], (i + 1) % NBYTES);
          break;
        end
    end
    total++; if (bits_seen - n0 != NBITS) begin bad++; $display("FAIL %s bit_count got=%0d want=%0d", tag, bits_seen - n0, NBITS); end
    total++; if (done_seen - d0 != 1) begin bad++; $display("FAIL %s done_count got=%0d want=1", tag, done_seen - d0); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL %s bits_left got=%0d want=0", tag, exp_q.size()); exp_q.delete(); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s idle_busy got=%b want=0", tag, bus.busy); end
  endtask

  task automatic test_frame;
    run_frame("frame", 1'b0);
  endtask

  task automatic test_start_held;
    run_frame("start_held", 1'b1);
  endtask

  task automatic test_continuous;
    int n, busy_low, d0;
    busy_low = 0; d0 = done_seen;
    push_frame(); push_frame();
    bus.continuous = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.frame_done !== 1'b1 && n < 1000) begin
      @(negedge clk); n++;
      if (n > 3 && bus.busy !== 1'b1) busy_low++;
    end
    total++; if (n >= 1000) begin bad++; $display("FAIL cont_done1 got=timeout want=pulse"); end
    n = 0;
    do begin
      @(negedge clk); n++;
      if (bus.busy !== 1'b1) busy_low++;
    end while (bus.led_dout !== 1'b1 && n < 10);
    total++; if (n < 1 || n > 2) begin bad++; $display("FAIL cont_restart got=%0d want=1..2", n); end
    repeat (50) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_low++;
    end
    bus.continuous = 1'b0;
    n = 0;
    while (bus.frame_done !== 1'b1 && n < 1000) begin
      @(negedge clk); n++;
      if (bus.frame_done !== 1'b1 && bus.busy !== 1'b1) busy_low++;
    end
    total++; if (n >= 1000) begin bad++; $display("FAIL cont_done2 got=timeout want=pulse"); end
    total++; if (busy_low != 0) begin bad++; $display("FAIL cont_busy low_cycles=%0d want=0", busy_low); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL cont_busy_fall got=%b want=0", bus.busy); end
    repeat (400) @(negedge clk);
    total++; if (done_seen - d0 != 2) begin bad++; $display("FAIL cont_done_count got=%0d want=2", done_seen - d0); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL cont_bits_left got=%0d want=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid;
    int n, n0, d0;
    push_frame();
    n0 = bits_seen; d0 = done_seen;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bits_seen < n0 + 20 && n < 2000) begin @(negedge clk); n++; end
    total++; if (n >= 2000) begin bad++; $display("FAIL rstmid_reach got=timeout want=bit20"); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.led_dout !== 1'b0)   begin bad++; $display("FAIL rstmid_led got=%b want=0", bus.led_dout); end
    total++; if (bus.busy !== 1'b0)       begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
    total++; if (bus.mem_addr !== '0)     begin bad++; $display("FAIL rstmid_addr got=%0d want=0", bus.mem_addr); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", bus.frame_done); end
    exp_q.delete();
    rst = 1'b0;
    repeat (400) @(negedge clk);
    total++; if (done_seen != d0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=%0d", done_seen, d0); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b want=0", bus.busy); end
    ram[0] = 8'h0F; ram[1] = 8'hF0; ram[2] = 8'h55; ram[3] = 8'hAA; ram[4] = 8'h81; ram[5] = 8'h7E;
    run_frame("after_rst", 1'b0);
  endtask

`ifdef BRIGHTNESS_SCALE_EN
  task automatic test_brightness;
    ram[0] = 8'hFF; ram[1] = 8'h80; ram[2] = 8'h01; ram[3] = 8'hFF; ram[4] = 8'hC3; ram[5] = 8'h00;
    bus.brightness = 8'd127;
    run_frame("bright127", 1'b0);
    bus.brightness = 8'd0;
    run_frame("bright0", 1'b0);
    bus.brightness = 8'd255;
    run_frame("bright255", 1'b0);
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[0] = 8'hA5; ram[1] = 8'h00; ram[2] = 8'hFF; ram[3] = 8'h01; ram[4] = 8'h80; ram[5] = 8'h3C;
    bus.start = 1'b0;
    bus.continuous = 1'b0;
`ifdef BRIGHTNESS_SCALE_EN
    bus.brightness = 8'd255;
`endif
    test_reset();
    test_frame();
    test_start_held();
    test_continuous();
    test_reset_mid();
`ifdef BRIGHTNESS_SCALE_EN
    test_brightness();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
